// File: rtl/riscv_memory_if.sv
// Core-side bus for riscv_memory: instruction fetch port, byte-lane data port,
// halt request and status. Lane i of the data buses maps to byte mem_addr+i.
interface riscv_memory_if;
    logic [31:0]     inst_addr;
    logic [31:0]     inst;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic [0:3][7:0] mem_data_out;
    logic            mem_write_en;
    logic            halted;
    logic            ready;
    logic            err;
    logic [15:0]     wr_count;

    modport master (
        output inst_addr, mem_addr, mem_data_in, mem_write_en, halted,
        input  inst, mem_data_out, ready, err, wr_count
    );

    modport slave (
        input  inst_addr, mem_addr, mem_data_in, mem_write_en, halted,
        output inst, mem_data_out, ready, err, wr_count
    );
endinterface

// File: rtl/riscv_memory.sv
// Word-organised unified instruction/data memory with write sequencing and error tracking.
// Optional feature: define MEM_CLEAR_EN to zero the whole array, one word per cycle, after reset.
module riscv_memory #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst_b,
    riscv_memory_if.slave bus
);
    localparam int WAW   = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** WAW;

    // state | meaning
    // CLEAR | zeroing one word per cycle; writes ignored, reads return 0
    // READY | normal operation; aligned in-range writes commit
    // HALT  | core halted; writes ignored, reads still served; left only by reset
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        READY = 2'd1,
        HALT  = 2'd2
    } state_t;

`ifdef MEM_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = READY;
`endif

    state_t          state;
    state_t          state_nxt;
    logic            ready_c;
    logic            in_clear;
    logic            clr_last;

    logic [31:0]     mem [WORDS];

    logic            wr_req;
    logic            wr_oor;
    logic            wr_bad;
    logic            wr_commit;
    logic [31:0]     wr_word;
    logic            mem_we;
    logic [WAW-1:0]  mem_widx;
    logic [31:0]     mem_wdata;

    logic            err_q;
    logic [15:0]     wr_count_q;

    logic            inst_oor;
    logic [31:0]     lane_addr [4];
    logic [31:0]     lane_word [4];
    logic [0:3][7:0] rd_lanes;

`ifdef MEM_CLEAR_EN
    logic [WAW-1:0]  clr_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign clr_last = &clr_cnt;
`else
    assign clr_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        unique case (state)
            CLEAR: begin
                if (clr_last) state_nxt = READY;
            end
            READY: begin
                ready_c = 1'b1;
                if (bus.halted) state_nxt = HALT;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    assign in_clear = (state == CLEAR);

    assign wr_req    = (state == READY) && bus.mem_write_en;
    assign wr_oor    = (bus.mem_addr >> ADDR_WIDTH) != 32'd0;
    assign wr_bad    = wr_req && ((bus.mem_addr[1:0] != 2'b00) || wr_oor);
    assign wr_commit = wr_req && !wr_bad;

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = bus.mem_data_in[i];
        end
    end

    // Reset must never touch the array, so every write port is gated by rst_b.
    always_comb begin
        mem_we    = wr_commit;
        mem_widx  = bus.mem_addr[ADDR_WIDTH-1:2];
        mem_wdata = wr_word;
`ifdef MEM_CLEAR_EN
        if (in_clear) begin
            mem_we    = 1'b1;
            mem_widx  = clr_cnt;
            mem_wdata = '0;
        end
`endif
        if (!rst_b) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            if (wr_bad) err_q <= 1'b1;
            if (wr_commit && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign inst_oor = (bus.inst_addr >> ADDR_WIDTH) != 32'd0;

    always_comb begin
        bus.inst = '0;
        if (!in_clear && !inst_oor) begin
            bus.inst = mem[bus.inst_addr[ADDR_WIDTH-1:2]];
        end
    end

    // Each lane resolves its own byte address, so misaligned reads may span two words.
    always_comb begin
        rd_lanes = '0;
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = bus.mem_addr + 32'(i);
            lane_word[i] = mem[lane_addr[i][ADDR_WIDTH-1:2]];
            if (!in_clear && ((lane_addr[i] >> ADDR_WIDTH) == 32'd0)) begin
                unique case (lane_addr[i][1:0])
                    2'd0:    rd_lanes[i] = lane_word[i][7:0];
                    2'd1:    rd_lanes[i] = lane_word[i][15:8];
                    2'd2:    rd_lanes[i] = lane_word[i][23:16];
                    default: rd_lanes[i] = lane_word[i][31:24];
                endcase
            end
        end
    end

    assign bus.mem_data_out = rd_lanes;
    assign bus.ready        = ready_c;
    assign bus.err          = err_q;
    assign bus.wr_count     = wr_count_q;

endmodule

// File: tb/tb_riscv_memory.sv
// Scoreboard bench for riscv_memory: a byte-level reference model predicts every cycle's
// outputs, a negedge monitor pops and compares. Works with or without MEM_CLEAR_EN.
module tb_riscv_memory;
    localparam int          AW        = 12;
    localparam int unsigned MEM_BYTES = 32'd1 << AW;
    localparam int          WDOG_CYC  = 95000;
`ifdef MEM_CLEAR_EN
    localparam int          CLR_LEN   = 1 << (AW - 2);
`else
    localparam int          CLR_LEN   = 0;
`endif

    logic clk;
    logic rst_b;

    riscv_memory_if bus ();

    riscv_memory #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] inst_mask;
        logic [31:0] data;
        logic [31:0] data_mask;
        logic        ready;
        logic        err;
        logic [15:0] wrc;
    } exp_t;

    exp_t        sb_q [$];
    logic [7:0]  mdl_mem [int unsigned];
    int          clear_left;
    bit          halt_st;
    bit          err_m;
    int          wrc_m;
    int          n_checks;
    int          n_pass;

    function automatic void check(input string nm, input string what,
                                  input logic [31:0] act, input logic [31:0] exp,
                                  input logic [31:0] mask);
        n_checks++;
        if (((act ^ exp) & mask) === 32'd0) n_pass++;
        else $display("FAIL %s.%s: got %h, expected %h (byte mask %h)", nm, what, act, exp, mask);
    endfunction

    function automatic void model_reset();
        clear_left = CLR_LEN;
        halt_st    = 1'b0;
        err_m      = 1'b0;
        wrc_m      = 0;
    endfunction

    // Byte value the core would see at address a; k=0 when storage there was never defined.
    function automatic void model_byte(input logic [31:0] a, output logic [7:0] v, output bit k);
        v = 8'h00;
        k = 1'b1;
        if (clear_left == 0 && a < MEM_BYTES) begin
            if (mdl_mem.exists(a)) v = mdl_mem[a];
            else k = 1'b0;
        end
    endfunction

    function automatic exp_t predict(input string nm, input logic [31:0] ia, input logic [31:0] ma);
        exp_t        e;
        logic [7:0]  v;
        bit          k;
        e.name      = nm;
        e.inst      = '0;
        e.inst_mask = '0;
        e.data      = '0;
        e.data_mask = '0;
        for (int i = 0; i < 4; i++) begin
            model_byte((ia & ~32'd3) + 32'(i), v, k);
            e.inst[8*i +: 8]      = v;
            e.inst_mask[8*i +: 8] = {8{k}};
            model_byte(ma + 32'(i), v, k);
            e.data[8*i +: 8]      = v;
            e.data_mask[8*i +: 8] = {8{k}};
        end
        e.ready = (clear_left == 0) && !halt_st;
        e.err   = err_m;
        e.wrc   = 16'(wrc_m);
        return e;
    endfunction

    function automatic void model_edge(input logic [31:0] ma, input logic [31:0] wd,
                                       input logic we, input logic h);
        if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int unsigned a = 0; a < MEM_BYTES; a++) mdl_mem[a] = 8'h00;
            end
        end else if (!halt_st) begin
            if (we) begin
                if (ma[1:0] != 2'b00 || ma >= MEM_BYTES) begin
                    err_m = 1'b1;
                end else begin
                    for (int i = 0; i < 4; i++) mdl_mem[ma + 32'(i)] = wd[8*i +: 8];
                    if (wrc_m < 65535) wrc_m++;
                end
            end
            if (h) halt_st = 1'b1;
        end
    endfunction

    // Called at posedge+1; drives one cycle of inputs and queues the expected response.
    task automatic drive(input string nm, input logic [31:0] ia, input logic [31:0] ma,
                         input logic [31:0] wd, input logic we, input logic h);
        bus.inst_addr    = ia;
        bus.mem_addr     = ma;
        bus.mem_write_en = we;
        bus.halted       = h;
        for (int i = 0; i < 4; i++) bus.mem_data_in[i] = wd[8*i +: 8];
        sb_q.push_back(predict(nm, ia, ma));
        @(posedge clk);
        #1;
        model_edge(ma, wd, we, h);
    endtask

    // Reset is held with a write request pending to show the array is left alone.
    task automatic do_reset(input int hold);
        bus.mem_addr     = 32'h10;
        bus.mem_write_en = 1'b1;
        bus.halted       = 1'b0;
        for (int i = 0; i < 4; i++) bus.mem_data_in[i] = 8'hEE;
        rst_b = 1'b0;
        model_reset();
        sb_q.push_back(predict("reset", bus.inst_addr, bus.mem_addr));
        repeat (hold) @(posedge clk);
        #1;
        bus.mem_write_en = 1'b0;
        rst_b = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6)      return {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        else if (r < 8) return 32'($urandom_range(0, MEM_BYTES - 1));
        else if (r < 9) return 32'($urandom_range(MEM_BYTES - 4, MEM_BYTES + 4));
        else            return $urandom;
    endfunction

    task automatic clear_phase(input string nm, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive(nm, rand_addr(), {20'd0, 10'($urandom_range(0, 1023)), 2'b00},
                  $urandom, 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act_data;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 4; i++) act_data[8*i +: 8] = bus.mem_data_out[i];
            if (e.inst_mask != 32'd0) check(e.name, "inst", bus.inst, e.inst, e.inst_mask);
            if (e.data_mask != 32'd0) check(e.name, "mem_data_out", act_data, e.data, e.data_mask);
            check(e.name, "ready", 32'(bus.ready), 32'(e.ready), 32'h1);
            check(e.name, "err", 32'(bus.err), 32'(e.err), 32'h1);
            check(e.name, "wr_count", 32'(bus.wr_count), 32'(e.wrc), 32'hFFFF);
        end
    end

    initial begin
        #(10 * WDOG_CYC);
        $display("FAIL watchdog: run exceeded %0d cycles, required to finish earlier", WDOG_CYC);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        rst_b            = 1'b0;
        bus.inst_addr    = '0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;
        bus.halted       = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(3);

        // Power-up clear: writes and halt requests must be ignored until ready rises.
        clear_phase("clear0", CLR_LEN);
        drive("post_clear", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        drive("wr10",   32'h0,    32'h10,   32'h12345678, 1'b1, 1'b0);
        drive("rd10",   32'h12,   32'h10,   32'h0,        1'b0, 1'b0);
        drive("wr13",   32'h10,   32'h13,   32'hAABBCCDD, 1'b1, 1'b0);
        drive("rd10b",  32'h10,   32'h10,   32'h0,        1'b0, 1'b0);
        drive("wr20",   32'h20,   32'h20,   32'hCAFEF00D, 1'b1, 1'b0);
        drive("rd20",   32'h20,   32'h20,   32'h0,        1'b0, 1'b0);
        drive("wr1000", 32'h1000, 32'h1000, 32'h01020304, 1'b1, 1'b0);
        drive("rd1000", 32'h1000, 32'h1000, 32'h0,        1'b0, 1'b0);
        drive("rd_span", 32'h13,  32'h0E,   32'h0,        1'b0, 1'b0);
        drive("rd_top",  32'hFFF, 32'hFFE,  32'h0,        1'b0, 1'b0);

        for (int c = 0; c < 400; c++) begin
            drive("rand", rand_addr(), rand_addr(), $urandom, 1'($urandom_range(0, 2) != 0), 1'b0);
        end

        do_reset(2);
`ifdef MEM_CLEAR_EN
        clear_phase("clear_part", 500);
        do_reset(1);
`endif
        clear_phase("clear1", CLR_LEN);
        drive("rd10_after_rst", 32'h10, 32'h10, 32'h0, 1'b0, 1'b0);

        drive("wr44",       32'h44, 32'h44, 32'h0BADBEEF, 1'b1, 1'b0);
        drive("halt_wr40",  32'h40, 32'h40, 32'h11223344, 1'b1, 1'b1);
        drive("halt_rd40",  32'h40, 32'h40, 32'h0,        1'b0, 1'b0);
        drive("halt_wr44",  32'h44, 32'h44, 32'h55667788, 1'b1, 1'b0);
        drive("halt_rd44",  32'h44, 32'h44, 32'h0,        1'b0, 1'b0);
        drive("halt_wr_bad", 32'h0, 32'h43, 32'h0,        1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            drive("halt_rand", rand_addr(), rand_addr(), $urandom, 1'b1, 1'($urandom_range(0, 1)));
        end

        do_reset(1);
        clear_phase("clear2", CLR_LEN);
        for (int c = 0; c < 70000; c++) begin
            drive("sat", rand_addr(), {20'd0, 10'($urandom_range(0, 1023)), 2'b00},
                  $urandom, 1'b1, 1'b0);
        end
        drive("sat_hold", 32'h10, 32'h10, 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_memory.md
RISCV_MEMORY -- requirements
Module: riscv_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: byte-address width of the storage; 2**ADDR_WIDTH bytes, organised as 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 inst_addr  input  32  instruction fetch byte address from the core.
REQ-005 inst  output  32  instruction word at inst_addr, little-endian.
REQ-006 mem_addr  input  32  data access byte address from the core.
REQ-007 mem_data_in  input  8 x [0:3]  write data byte lanes; lane i targets byte mem_addr+i.
REQ-008 mem_data_out  output  8 x [0:3]  read data byte lanes; lane i = byte mem_addr+i.
REQ-009 mem_write_en  input  1  data write request for the current cycle.
REQ-010 halted  input  1  core halt indication.
REQ-011 ready  output  1  high when the memory accepts writes.
REQ-012 err  output  1  sticky access-error flag.
REQ-013 wr_count  output  16  count of committed writes, saturating.

Function
REQ-014 The controller SHALL have states CLEAR, READY and HALT.
- CLEAR -> READY when the clear counter passes the last word.
- READY -> HALT when halted=1 at a rising edge.
- HALT exits only via reset.
REQ-015 CLEAR SHALL zero one word per cycle, starting at word 0 and incrementing, for 2**(ADDR_WIDTH-2) cycles in total; ready=0 throughout.
REQ-016 ready SHALL be 1 in READY and 0 in CLEAR and HALT.
REQ-017 Reads SHALL be combinational.
- inst = word at inst_addr[ADDR_WIDTH-1:2]; mem_data_out = bytes at mem_addr..mem_addr+3.
- Both SHALL return 0 while in CLEAR.
REQ-018 An address is out of range when any bit at or above ADDR_WIDTH is set.
- Reads at an out-of-range address SHALL return 0.
- inst_addr[1:0] SHALL be ignored.
REQ-019 A write SHALL commit at the rising edge only when all of the following hold:
- state is READY and mem_write_en=1;
- mem_addr[1:0]=0;
- mem_addr is in range.
On commit, all 4 lanes are written.
REQ-020 mem_write_en=1 in READY with a misaligned or out-of-range mem_addr SHALL suppress the write and set err=1 at that edge.
REQ-021 mem_write_en in CLEAR or HALT SHALL be ignored, SHALL NOT set err, and SHALL NOT count.
REQ-022 A write and a read of the same word in the same cycle SHALL return the old value before the edge and the new value after it; no forwarding.
REQ-023 wr_count SHALL increment by 1 on each committed write and hold at 16'hFFFF.
REQ-024 If halted=1 and a valid write occur in the same READY cycle, the write SHALL commit and the state SHALL enter HALT.
REQ-025 err SHALL stay 1 until reset.

Reset
REQ-026 rst_b=0 SHALL immediately force:
- state CLEAR (READY when MEM_CLEAR_EN is undefined);
- clear counter 0, err=0, wr_count=0.
REQ-027 Storage contents SHALL NOT be altered by reset itself.
REQ-028 Reset asserted mid-CLEAR SHALL restart clearing from word 0 after release.
REQ-029 Reset in HALT SHALL return to CLEAR (or READY).

Configuration
REQ-030 Macro MEM_CLEAR_EN:
- Defined: the CLEAR state and clear counter exist, and behaviour is as in REQ-015.
- Undefined: CLEAR and its counter are omitted; reset enters READY directly with ready=1 on the first cycle, and storage starts uninitialised.

Verification
REQ-031 MEM_CLEAR_EN, ADDR_WIDTH=12: release reset -> ready=0 for exactly 1024 cycles, then ready=1; read of any word -> 0.
REQ-032 Write mem_addr=0x10, lanes {0x78,0x56,0x34,0x12}, mem_write_en=1 for 1 cycle -> next cycle mem_data_out={0x78,0x56,0x34,0x12}, inst_addr=0x12 gives inst=0x12345678, wr_count=1.
REQ-033 Write mem_addr=0x13 -> no storage change, err=1, wr_count unchanged; then a valid write to 0x20 -> commits, err remains 1.
REQ-034 Write mem_addr=0x1000 -> suppressed, err=1; read at 0x1000 -> 0.
REQ-035 halted=1 with a valid write to 0x40 in the same cycle -> 0x40 updated, ready=0; a later write to 0x44 is ignored, err=0.
REQ-036 Assert rst_b=0 at clear cycle 500 -> after release, ready=0 for a full 1024 cycles; 70000 valid writes -> wr_count=0xFFFF.
